// File: rtl/iic_pkg.sv
// iic_pkg: shared state/quarter types for the byte-level I2C initiator.
// Optional slave clock stretching is enabled by defining IIC_CLK_STRETCH_EN.
package iic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      BIT,
      ACK,
      STOP,
      HOLD
   } state_t;

   typedef enum logic [1:0] {
      Q0,
      Q1,
      Q2,
      Q3
   } qtr_t;

   localparam int DEF_CLK_DIV = 250;

endpackage

// File: rtl/iic_qtick.sv
// iic_qtick: quarter-SCL-period tick generator with clear and stall.
// tick pulses for one cycle on the last count of each quarter.
module iic_qtick #(
   parameter int DIV = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic stall,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(DIV - 1);

   logic [15:0] cnt;

   assign tick = !clr && !stall && (cnt == LAST);

   // free-running quarter counter, frozen while stalled
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (!stall) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
      end
   end

endmodule

// File: rtl/iic_master.sv
// iic_master: byte-level I2C initiator (START, 8 bits + ACK, STOP).
// Define IIC_CLK_STRETCH_EN to add scl_in and honour slave stretching.
module iic_master
   import iic_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV,
   parameter int CH_W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_start,
   input  logic            cmd_stop,
   input  logic            cmd_rd,
   input  logic [CH_W-1:0] cmd_ch,
   input  logic [7:0]      cmd_wdata,
   input  logic            cmd_mack,
   output logic            rsp_valid,
   output logic [7:0]      rsp_rdata,
   output logic            rsp_nack,
   output logic            busy,
   output logic [CH_W-1:0] iic_sel,
   output logic            scl,
   output logic            sda_oe,
   input  logic            sda_in
`ifdef IIC_CLK_STRETCH_EN
   ,
   input  logic            scl_in
`endif
);

   state_t     state;
   qtr_t       q;
   logic [2:0] bcnt;
   logic [7:0] sr;
   logic       rd;
   logic       stop;
   logic       mack;
   logic       ackb;
   logic       rstart;
   logic       tick;
   logic       clr;
   logic       stall;
   logic [7:0] fin_rdata;
   logic       fin_nack;

   assign clr = (state == IDLE) || (state == HOLD);

`ifdef IIC_CLK_STRETCH_EN
   assign stall = (q == Q1) && scl && !scl_in;
`else
   assign stall = 1'b0;
`endif

   assign fin_rdata = rd ? sr : 8'h00;
   assign fin_nack  = !rd && ackb;

   iic_qtick #(
      .DIV(CLK_DIV)
   ) u_qtick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .stall(stall),
      .tick (tick)
   );

   // bus sequencer: each quarter tick steps state/quarter and pins
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         q         <= Q0;
         bcnt      <= '0;
         sr        <= '0;
         rd        <= 1'b0;
         stop      <= 1'b0;
         mack      <= 1'b0;
         ackb      <= 1'b0;
         rstart    <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_nack  <= 1'b0;
         busy      <= 1'b0;
         iic_sel   <= '0;
         scl       <= 1'b1;
         sda_oe    <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE, HOLD: begin
               if (cmd_valid && cmd_ready) begin
                  rd   <= cmd_rd;
                  stop <= cmd_stop;
                  mack <= cmd_mack;
                  sr   <= cmd_wdata;
                  bcnt <= '0;
                  q    <= Q0;
                  if (cmd_start) begin
                     state     <= START;
                     iic_sel   <= cmd_ch;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                     rstart    <= (state == HOLD);
                     scl       <= (state == IDLE);
                     sda_oe    <= 1'b0;
                  end else if (state == HOLD) begin
                     state     <= BIT;
                     cmd_ready <= 1'b0;
                     scl       <= 1'b0;
                     sda_oe    <= !cmd_rd && !cmd_wdata[7];
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_nack  <= 1'b1;
                     rsp_rdata <= 8'h00;
                  end
               end
            end
            START: begin
               if (tick) begin
                  case (q)
                     Q0: begin
                        q      <= Q1;
                        scl    <= 1'b1;
                        sda_oe <= !rstart;
                     end
                     Q1: begin
                        q      <= Q2;
                        sda_oe <= 1'b1;
                     end
                     Q2: begin
                        q   <= Q3;
                        scl <= 1'b0;
                     end
                     Q3: begin
                        q      <= Q0;
                        state  <= BIT;
                        sda_oe <= !rd && !sr[7];
                     end
                  endcase
               end
            end
            BIT: begin
               if (tick) begin
                  case (q)
                     Q0: begin
                        q   <= Q1;
                        scl <= 1'b1;
                     end
                     Q1: q <= Q2;
                     Q2: begin
                        q   <= Q3;
                        scl <= 1'b0;
                        sr  <= {sr[6:0], sda_in};
                     end
                     Q3: begin
                        q <= Q0;
                        if (bcnt == 3'd7) begin
                           state  <= ACK;
                           sda_oe <= rd && mack;
                        end else begin
                           bcnt   <= bcnt + 3'd1;
                           sda_oe <= !rd && !sr[7];
                        end
                     end
                  endcase
               end
            end
            ACK: begin
               if (tick) begin
                  case (q)
                     Q0: begin
                        q   <= Q1;
                        scl <= 1'b1;
                     end
                     Q1: q <= Q2;
                     Q2: begin
                        q    <= Q3;
                        scl  <= 1'b0;
                        ackb <= sda_in;
                     end
                     Q3: begin
                        q <= Q0;
                        if (stop) begin
                           state  <= STOP;
                           sda_oe <= 1'b1;
                        end else begin
                           state     <= HOLD;
                           sda_oe    <= 1'b0;
                           rsp_valid <= 1'b1;
                           rsp_rdata <= fin_rdata;
                           rsp_nack  <= fin_nack;
                           cmd_ready <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            STOP: begin
               if (tick) begin
                  case (q)
                     Q0: begin
                        q   <= Q1;
                        scl <= 1'b1;
                     end
                     Q1: begin
                        q      <= Q2;
                        sda_oe <= 1'b0;
                     end
                     Q2: q <= Q3;
                     Q3: begin
                        q         <= Q0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= fin_rdata;
                        rsp_nack  <= fin_nack;
                        cmd_ready <= 1'b1;
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iic_master.sv
// tb_iic_master: directed command table against a small I2C slave model.
// Build with IIC_CLK_STRETCH_EN defined to add the stretching sequence.
module tb_iic_master;

   typedef struct {
      int start;
      int stop;
      int rd;
      int mack;
      int snack;
      int ch;
      int wdata;
      int sbyte;
      int rdata;
      int nack;
      int busy;
      int sel;
      int lat;
      int falls;
      int starts;
      int stops;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_start = 1'b0;
   logic       cmd_stop = 1'b0;
   logic       cmd_rd = 1'b0;
   logic [7:0] cmd_ch = 8'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       cmd_mack = 1'b0;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       busy;
   logic [7:0] iic_sel;
   logic       scl;
   logic       sda_oe;
   logic       sda_in;

   int         rcnt = 0;
   bit         done = 1'b1;
   bit         skip = 1'b0;
   logic       pull;
   logic       s_rd = 1'b0;
   logic       s_nack = 1'b0;
   logic [7:0] s_byte = 8'h00;
   logic [7:0] sh = 8'h00;
   logic [7:0] obs = 8'h00;
   logic       ack_oe = 1'b0;
   int         falls = 0;
   int         starts = 0;
   int         stops = 0;
   int         pass = 0;
   int         total = 0;
   bit         held = 1'b0;
   vec_t       tv[7];

`ifdef IIC_CLK_STRETCH_EN
   logic stretch = 1'b0;
   logic scl_in;
   assign scl_in = scl && !stretch;
`endif

   always #5 clk = ~clk;

   iic_master #(
      .CLK_DIV(4),
      .CH_W   (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_start(cmd_start),
      .cmd_stop (cmd_stop),
      .cmd_rd   (cmd_rd),
      .cmd_ch   (cmd_ch),
      .cmd_wdata(cmd_wdata),
      .cmd_mack (cmd_mack),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_nack (rsp_nack),
      .busy     (busy),
      .iic_sel  (iic_sel),
      .scl      (scl),
      .sda_oe   (sda_oe),
      .sda_in   (sda_in)
`ifdef IIC_CLK_STRETCH_EN
      ,
      .scl_in   (scl_in)
`endif
   );

   // slave drives data bit rcnt (read) or ACK (write) on the open-drain line
   always_comb begin
      pull = 1'b0;
      if (!done && !skip && rcnt < 8) begin
         pull = s_rd && !s_byte[7-rcnt];
      end else if (!done && !skip && rcnt == 8) begin
         pull = !s_rd && !s_nack;
      end
   end

   assign sda_in = !(sda_oe || pull);

   always @(negedge sda_in) begin
      if (scl === 1'b1) begin
         starts++;
         rcnt = 0;
         done = 1'b0;
         skip = 1'b1;
      end
   end

   always @(posedge sda_in) begin
      if (scl === 1'b1) stops++;
   end

   always @(posedge scl) begin
      sh = {sh[6:0], sda_in};
      if (!done && !skip && rcnt == 7) obs = sh;
      if (!done && !skip && rcnt == 8) ack_oe = sda_oe;
   end

   always @(negedge scl) begin
      falls++;
      if (skip) begin
         skip = 1'b0;
      end else if (!done) begin
         rcnt++;
         if (rcnt == 9) begin
            rcnt = 0;
            done = 1'b1;
         end
      end
   end

   task automatic chk(input int id, input string nm,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL v%0d %s: got %0h expected %0h", id, nm, act, exp);
   endtask

   function automatic vec_t mk(int st, int sp, int rd, int mk_, int sn,
                               int ch, int wd, int sb, int rdat, int nk,
                               int by, int sel, int lat, int fl,
                               int ns, int np);
      vec_t v;
      v.start = st;  v.stop = sp;   v.rd = rd;    v.mack = mk_;
      v.snack = sn;  v.ch = ch;     v.wdata = wd; v.sbyte = sb;
      v.rdata = rdat; v.nack = nk;  v.busy = by;  v.sel = sel;
      v.lat = lat;   v.falls = fl;  v.starts = ns; v.stops = np;
      return v;
   endfunction

   task automatic run(input int id, input vec_t v);
      int lat;
      @(negedge clk);
      chk(id, "ready_in", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_start = v.start[0];
      cmd_stop  = v.stop[0];
      cmd_rd    = v.rd[0];
      cmd_mack  = v.mack[0];
      cmd_ch    = 8'(v.ch);
      cmd_wdata = 8'(v.wdata);
      s_rd   = v.rd[0];
      s_nack = v.snack[0];
      s_byte = 8'(v.sbyte);
      falls = 0; starts = 0; stops = 0;
      obs = 8'h00; ack_oe = 1'b0;
      if (v.start == 0 && held) done = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_ch    = 8'hEE;
      lat = 1;
      while (!rsp_valid && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      chk(id, "latency", lat, v.lat);
      chk(id, "rsp_nack", rsp_nack, v.nack);
      chk(id, "rsp_rdata", rsp_rdata, v.rdata);
      chk(id, "busy", busy, v.busy);
      chk(id, "iic_sel", iic_sel, v.sel);
      chk(id, "scl_end", scl, (v.busy != 0) ? 0 : 1);
      chk(id, "ready_out", cmd_ready, 1);
      chk(id, "scl_falls", falls, v.falls);
      chk(id, "starts", starts, v.starts);
      chk(id, "stops", stops, v.stops);
      if (v.falls > 0) begin
         chk(id, "sda_byte", obs, (v.rd != 0) ? v.sbyte : v.wdata);
         chk(id, "ack_oe", ack_oe, (v.rd != 0) ? v.mack : 0);
      end
      @(negedge clk);
      chk(id, "rsp_pulse", rsp_valid, 0);
      held = (v.busy != 0);
   endtask

   initial begin
      int n;
      tv[0] = mk(0, 0, 0, 0, 0, 5, 8'h77, 0, 0, 1, 0, 0, 1, 0, 0, 0);
      tv[1] = mk(1, 1, 0, 0, 0, 3, 8'hA5, 0, 0, 0, 0, 3, 177, 10, 1, 1);
      tv[2] = mk(1, 0, 0, 0, 1, 6, 8'h90, 0, 0, 1, 1, 6, 161, 10, 1, 0);
      tv[3] = mk(0, 0, 0, 0, 0, 7, 8'h11, 0, 0, 0, 1, 6, 145, 9, 0, 0);
      tv[4] = mk(1, 1, 1, 0, 0, 2, 0, 8'h3C, 8'h3C, 0, 0, 2, 177, 10, 1, 1);
      tv[5] = mk(1, 0, 1, 1, 0, 4, 0, 8'hC3, 8'hC3, 0, 1, 4, 161, 10, 1, 0);
      tv[6] = mk(0, 1, 0, 0, 0, 1, 8'h5A, 0, 0, 0, 0, 4, 161, 9, 0, 1);

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk(90, "rst_ready", cmd_ready, 1);
      chk(90, "rst_valid", rsp_valid, 0);
      chk(90, "rst_rdata", rsp_rdata, 0);
      chk(90, "rst_nack", rsp_nack, 0);
      chk(90, "rst_busy", busy, 0);
      chk(90, "rst_sel", iic_sel, 0);
      chk(90, "rst_scl", scl, 1);
      chk(90, "rst_sda", sda_oe, 0);

      for (int i = 0; i < 7; i++) run(i, tv[i]);

`ifdef IIC_CLK_STRETCH_EN
      fork
         run(7, mk(1, 1, 0, 0, 0, 3, 8'hA5, 0, 0, 0, 0, 3, 197, 10, 1, 1));
         begin
            int m = 0;
            @(negedge clk);
            while (!(rcnt == 2 && !done && !skip && scl) && m < 1000) begin
               @(negedge clk);
               m++;
            end
            stretch = 1'b1;
            repeat (20) @(negedge clk);
            stretch = 1'b0;
         end
      join
`endif

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_start = 1'b1;
      cmd_stop  = 1'b1;
      cmd_rd    = 1'b0;
      cmd_ch    = 8'h05;
      cmd_wdata = 8'hFF;
      s_rd = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!(rcnt == 4 && !done && !skip && scl) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(91, "bit4_reached", rcnt, 4);
      chk(91, "busy_mid", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk(91, "abort_scl", scl, 1);
      chk(91, "abort_sda", sda_oe, 0);
      chk(91, "abort_busy", busy, 0);
      chk(91, "abort_sel", iic_sel, 0);
      chk(91, "abort_ready", cmd_ready, 1);
      chk(91, "abort_valid", rsp_valid, 0);
      done = 1'b1;
      rcnt = 0;

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
